// File: rtl/lsu_byte_master.sv
// lsu_byte_master: load/store unit, initiator side of a byte-wide
// big-endian data-memory port, one byte per cycle.
// Ports:
//   clk, rst          clock, async active-high reset
//   req_valid/ready   core request handshake (ready only in IDLE)
//   req_we/addr/mode  store flag, byte address, access mode
//   req_wdata         store data (low 8/16/32 bits used)
//   rsp_valid/rdata   one-cycle completion pulse, extended load data
//   rsp_err           illegal mode, misaligned or out of range
//   mem_rd_en/wr_en   byte read / write strobes
//   mem_addr/wdata    byte address and store byte
//   mem_rdata         asynchronous read data for mem_addr
module lsu_byte_master #(
  parameter int MEM_BYTES   = 100,
  parameter int ALIGN_CHECK = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_mode,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_rd_en,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t      state, state_d;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  mode_q;
  logic [31:0] wdata_q;
  logic        err_q;
  logic [2:0]  nb_q;
  logic [1:0]  cnt;
  logic [31:0] acc;

  logic [2:0]  nb_d;
  logic        mode_bad;
  logic        st_bad;
  logic        mis;
  logic        oor;
  logic        err_d;
  logic [32:0] end_addr;
  logic        last;
  logic [1:0]  idx;

  // Request decode, evaluated only when accepting in IDLE.
  always_comb begin
    nb_d     = 3'd1;
    mode_bad = 1'b0;
    case (req_mode)
      3'b000, 3'b100: nb_d = 3'd1;
      3'b001, 3'b101: nb_d = 3'd2;
      3'b010:         nb_d = 3'd4;
      default:        mode_bad = 1'b1;
    endcase
    st_bad = req_we & req_mode[2];
    mis = (ALIGN_CHECK != 0) &&
          (((nb_d == 3'd2) && req_addr[0]) ||
           ((nb_d == 3'd4) && (req_addr[1:0] != 2'b00)));
    // 33-bit sum so an address near 2^32 cannot wrap into range.
    end_addr = {1'b0, req_addr} + {30'b0, nb_d};
    oor = end_addr > 33'(MEM_BYTES);
    err_d = mode_bad | st_bad | mis | oor;
  end

  assign last = ({1'b0, cnt} == (nb_q - 3'd1));
  // Big-endian: first byte out is the most significant used byte.
  assign idx  = 2'(nb_q - 3'd1 - {1'b0, cnt});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (req_valid) state_d = err_d ? RESP : ACCESS;
      ACCESS:  if (last) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      addr_q  <= 32'd0;
      mode_q  <= 3'd0;
      wdata_q <= 32'd0;
      err_q   <= 1'b0;
      nb_q    <= 3'd1;
      cnt     <= 2'd0;
      acc     <= 32'd0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          we_q    <= req_we;
          addr_q  <= req_addr;
          mode_q  <= req_mode;
          wdata_q <= req_wdata;
          err_q   <= err_d;
          nb_q    <= nb_d;
          cnt     <= 2'd0;
          acc     <= 32'd0;
        end
        ACCESS: begin
          cnt <= cnt + 2'd1;
          if (!we_q) acc <= {acc[23:0], mem_rdata};
        end
        default: ;
      endcase
    end
  end

  // All outputs decode from registered state only.
  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 32'd0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_addr  = 32'd0;
    mem_wdata = 8'd0;
    if (state == ACCESS) begin
      mem_rd_en = ~we_q;
      mem_wr_en = we_q;
      mem_addr  = addr_q + {30'b0, cnt};
      if (we_q) begin
        case (idx)
          2'd0: mem_wdata = wdata_q[7:0];
          2'd1: mem_wdata = wdata_q[15:8];
          2'd2: mem_wdata = wdata_q[23:16];
          default: mem_wdata = wdata_q[31:24];
        endcase
      end
    end
    if (state == RESP) begin
      rsp_valid = 1'b1;
      rsp_err   = err_q;
      if (!we_q && !err_q) begin
        case (mode_q)
          3'b000: rsp_rdata = {{24{acc[7]}}, acc[7:0]};
          3'b001: rsp_rdata = {{16{acc[15]}}, acc[15:0]};
          3'b010: rsp_rdata = acc;
          3'b100: rsp_rdata = {24'd0, acc[7:0]};
          3'b101: rsp_rdata = {16'd0, acc[15:0]};
          default: rsp_rdata = 32'd0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master: directed self-checking bench for lsu_byte_master
// with a 128-byte behavioural memory.
module tb_lsu_byte_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [2:0]  req_mode = 3'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_rd_en;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:127];

  int passed = 0;
  int total  = 0;

  int          nrd, nwr, cyc;
  logic        both;
  logic [31:0] aseq, wseq, r_data;
  logic        r_err;
  logic [31:0] rdy_seq;
  logic [31:0] b2b_addr, b2b_d1, b2b_d2;
  int          strobes, rsps;

  lsu_byte_master #(.MEM_BYTES(100), .ALIGN_CHECK(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr),
    .req_mode(req_mode), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  assign mem_rdata = (mem_addr < 32'd128) ? mem[mem_addr[6:0]] : 8'h00;

  always @(posedge clk)
    if (mem_wr_en && mem_addr < 32'd128)
      mem[mem_addr[6:0]] <= mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic run_req(input logic we, input logic [31:0] a,
                         input logic [2:0] m, input logic [31:0] wd,
                         input bit tog);
    @(negedge clk);
    req_we = we; req_addr = a; req_mode = m; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    nrd = 0; nwr = 0; cyc = 0; both = 1'b0;
    aseq = 0; wseq = 0; r_data = 32'hx; r_err = 1'bx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (tog) begin
        req_valid = ~req_valid;
        req_addr = 32'h40;
        req_mode = 3'b111;
      end
      if (mem_rd_en && mem_wr_en) both = 1'b1;
      if (mem_rd_en) begin
        nrd++;
        aseq = {aseq[23:0], mem_addr[7:0]};
      end
      if (mem_wr_en) begin
        nwr++;
        aseq = {aseq[23:0], mem_addr[7:0]};
        wseq = {wseq[23:0], mem_wdata};
      end
      if (rsp_valid) begin
        cyc = k; r_data = rsp_rdata; r_err = rsp_err;
        req_valid = 1'b0;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic chk_err(input string tag);
    chk({tag, "_cyc"}, cyc, 1);
    chk({tag, "_err"}, {31'd0, r_err}, 1);
    chk({tag, "_data"}, r_data, 0);
    chk({tag, "_strb"}, nrd + nwr, 0);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    mem[8] = 8'h80; mem[9] = 8'h12; mem[10] = 8'h34; mem[11] = 8'h56;
    mem[96] = 8'h01; mem[97] = 8'h02; mem[98] = 8'h03; mem[99] = 8'h04;
    #12;
    chk("rst_ready", {31'd0, req_ready}, 1);
    chk("rst_rspv", {31'd0, rsp_valid}, 0);
    chk("rst_rd", {31'd0, mem_rd_en}, 0);
    chk("rst_wr", {31'd0, mem_wr_en}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_rdata", rsp_rdata, 0);
    @(negedge clk) rst = 1'b0;

    run_req(1'b0, 32'd8, 3'b010, 32'd0, 1'b0);
    chk("lw8_nrd", nrd, 4);
    chk("lw8_addr", aseq, 32'h08090a0b);
    chk("lw8_cyc", cyc, 5);
    chk("lw8_data", r_data, 32'h80123456);
    chk("lw8_err", {31'd0, r_err}, 0);

    run_req(1'b0, 32'd8, 3'b000, 32'd0, 1'b0);
    chk("lb8_cyc", cyc, 2);
    chk("lb8_data", r_data, 32'hffffff80);
    run_req(1'b0, 32'd8, 3'b100, 32'd0, 1'b0);
    chk("lbu8_data", r_data, 32'h00000080);
    run_req(1'b0, 32'd10, 3'b001, 32'd0, 1'b0);
    chk("lh10_cyc", cyc, 3);
    chk("lh10_data", r_data, 32'h00003456);
    run_req(1'b0, 32'd8, 3'b101, 32'd0, 1'b0);
    chk("lhu8_data", r_data, 32'h00008012);

    run_req(1'b1, 32'd4, 3'b010, 32'hdeadbeef, 1'b0);
    chk("sw4_nwr", nwr, 4);
    chk("sw4_nrd", nrd, 0);
    chk("sw4_addr", aseq, 32'h04050607);
    chk("sw4_wseq", wseq, 32'hdeadbeef);
    chk("sw4_cyc", cyc, 5);
    chk("sw4_data", r_data, 0);
    chk("sw4_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'hdeadbeef);
    run_req(1'b0, 32'd4, 3'b010, 32'd0, 1'b0);
    chk("lw4_data", r_data, 32'hdeadbeef);

    run_req(1'b1, 32'd2, 3'b001, 32'h1234abcd, 1'b0);
    chk("sh2_nwr", nwr, 2);
    chk("sh2_wseq", wseq, 32'h0000abcd);
    chk("sh2_mem", {16'd0, mem[2], mem[3]}, 32'h0000abcd);

    run_req(1'b0, 32'd6, 3'b010, 32'd0, 1'b0);
    chk_err("mis6");
    run_req(1'b0, 32'd96, 3'b010, 32'd0, 1'b0);
    chk("lw96_err", {31'd0, r_err}, 0);
    chk("lw96_data", r_data, 32'h01020304);
    chk("lw96_cyc", cyc, 5);
    run_req(1'b0, 32'd98, 3'b010, 32'd0, 1'b0);
    chk_err("oor98");
    run_req(1'b0, 32'hfffffffc, 3'b010, 32'd0, 1'b0);
    chk_err("wrap");
    run_req(1'b0, 32'd98, 3'b001, 32'd0, 1'b0);
    chk("lh98_err", {31'd0, r_err}, 0);
    chk("lh98_data", r_data, 32'h00000304);
    run_req(1'b1, 32'd8, 3'b100, 32'h55, 1'b0);
    chk_err("sbu");
    run_req(1'b0, 32'd8, 3'b111, 32'd0, 1'b0);
    chk_err("mode7");
    chk("chk8", {31'd0, mem[8] == 8'h80}, 1);

    // Back-to-back: request held, second accepted 3 cycles later.
    @(negedge clk);
    req_we = 1'b0; req_addr = 32'd8; req_mode = 3'b000;
    req_valid = 1'b1;
    @(posedge clk);
    rdy_seq = 0; b2b_addr = 0; b2b_d1 = 0; b2b_d2 = 0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      rdy_seq = {rdy_seq[27:0], 3'b000, req_ready};
      if (c == 2) begin
        b2b_d1 = rsp_rdata;
        req_addr = 32'd9;
      end
      if (c == 4) begin
        b2b_addr = mem_addr;
        req_valid = 1'b0;
      end
      if (c == 5) b2b_d2 = rsp_valid ? rsp_rdata : 32'hx;
    end
    chk("b2b_ready", rdy_seq, 32'h00100);
    chk("b2b_d1", b2b_d1, 32'hffffff80);
    chk("b2b_addr", b2b_addr, 32'd9);
    chk("b2b_d2", b2b_d2, 32'h00000012);

    run_req(1'b0, 32'd8, 3'b010, 32'd0, 1'b1);
    chk("tog_addr", aseq, 32'h08090a0b);
    chk("tog_cyc", cyc, 5);
    chk("tog_data", r_data, 32'h80123456);
    chk("never_both", {31'd0, both}, 0);

    // Async reset in the 2nd ACCESS cycle of a store.
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'd4; req_mode = 3'b010;
    req_wdata = 32'h11223344; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ar_wr_pre", {31'd0, mem_wr_en}, 1);
    chk("ar_addr_pre", mem_addr, 32'd5);
    #1 rst = 1'b1;
    #1 chk("ar_wr_drop", {31'd0, mem_wr_en}, 0);
    @(negedge clk) rst = 1'b0;
    strobes = 0; rsps = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (mem_wr_en || mem_rd_en) strobes++;
      if (rsp_valid) rsps++;
    end
    chk("ar_strobes", strobes, 0);
    chk("ar_rsp", rsps, 0);
    chk("ar_ready", {31'd0, req_ready}, 1);
    chk("ar_mem", {mem[4], mem[5], mem[6], mem[7]}, 32'h11adbeef);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/lsu_byte_master.md
Name: lsu_byte_master

Overview:
- Load/store unit: the initiator side of the data-memory access protocol.
- Accepts one load/store request at a time from the core and runs it against a byte-wide, big-endian data memory, one byte per cycle.
- For loads, assembles bytes MSB-first and sign- or zero-extends them into a 32-bit result.
- Sits between the core's execute/memory stage and the byte-addressed data memory.

Parameters:
- MEM_BYTES, 100: number of addressable bytes; accesses reaching addr+nbytes > MEM_BYTES are errors.
- ALIGN_CHECK, 1: 1 = halfword/word accesses must be naturally aligned, else error; 0 = no alignment check.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  core presents a request
- req_ready  out  1  LSU can accept (IDLE only)
- req_we  in  1  1 = store, 0 = load
- req_addr  in  32  byte address
- req_mode  in  3  000 BYTE, 001 HALFWORD, 010 WORD, 100 BYTE_UNSIGNED, 101 HALFWORD_UNSIGNED
- req_wdata  in  32  store data; low 8/16/all 32 bits used
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load result; 0 for stores and errors
- rsp_err  out  1  valid with rsp_valid; illegal mode, misaligned or out of range
- mem_rd_en  out  1  byte read strobe
- mem_wr_en  out  1  byte write strobe, sampled by memory at posedge clk
- mem_addr  out  32  byte address to memory
- mem_wdata  out  8  store byte
- mem_rdata  in  8  asynchronous read data for mem_addr

Behaviour:
- Reset (async, any state):
  - FSM goes to IDLE; counter and accumulator clear.
  - req_ready=1; rsp_valid=0, rsp_err=0, rsp_rdata=0.
  - mem_rd_en=0, mem_wr_en=0, mem_addr=0, mem_wdata=0.
  - Reset mid-access aborts the access: no further strobes and no response.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid at posedge, latch we/addr/mode/wdata.
  - nbytes = 1 for modes 000 and 100; 2 for 001 and 101; 4 for 010.
  - Errors:
    - mode 011, 110 or 111;
    - store with mode 100 or 101;
    - ALIGN_CHECK=1 and addr not a multiple of nbytes;
    - addr+nbytes > MEM_BYTES, computed 33 bits wide so wrap is caught.
  - Error -> RESP with err flag set, no memory strobe ever asserted.
  - Otherwise -> ACCESS with cnt=0, acc=0.
- ACCESS, one byte per cycle:
  - mem_addr = addr+cnt; mem_rd_en = ~we; mem_wr_en = we.
  - Store byte order is big-endian: mem_wdata = byte (nbytes-1-cnt) of wdata counted from the LSB, so the most significant used byte goes to the lowest address.
  - Load: at posedge, acc <= {acc[23:0], mem_rdata}.
  - At posedge, cnt <= cnt+1; when cnt == nbytes-1, go to RESP.
  - req_ready=0 for the whole access.
- RESP:
  - rsp_valid=1 for exactly one cycle; rsp_err as latched.
  - rsp_rdata for loads:
    - BYTE: sign-extend acc[7:0]
    - HALFWORD: sign-extend acc[15:0]
    - WORD: acc
    - BYTE_UNSIGNED: zero-extend acc[7:0]
    - HALFWORD_UNSIGNED: zero-extend acc[15:0]
  - rsp_rdata=0 for stores and errors.
  - Next state is IDLE; req_ready=0 during RESP.
- Outputs are registered or decoded from registered state only; no combinational path from req_* to mem_* or rsp_*.
- Latency from the accept edge: ACCESS occupies cycles 1..nbytes, rsp_valid is high in cycle nbytes+1, and the next accept is possible at the edge ending cycle nbytes+2.
  - Error response: rsp_valid in cycle 1.
- req_valid is ignored outside IDLE; the core must hold the request until it sees req_ready.
- mem_rd_en and mem_wr_en are never high together; both are 0 outside ACCESS.

Test Plan:
- Reset, then memory [8..11] = 0x80,0x12,0x34,0x56; WORD load at addr 8 -> mem_rd_en for 4 cycles at addresses 8,9,10,11; rsp_valid in cycle 5; rsp_rdata=0x80123456, rsp_err=0.
- BYTE load at addr 8 -> rsp_rdata=0xFFFFFF80. BYTE_UNSIGNED at addr 8 -> 0x00000080. HALFWORD at 10 -> 0x00003456. HALFWORD_UNSIGNED at 8 -> 0x00008012.
- WORD store 0xDEADBEEF at addr 4 -> mem_wr_en for 4 cycles writing DE,AD,BE,EF to addresses 4..7; then WORD load at 4 returns 0xDEADBEEF. HALFWORD store 0x1234ABCD at 2 writes AB then CD.
- Errors, each giving rsp_valid in cycle 1 with rsp_err=1, rsp_rdata=0 and no mem strobes:
  - WORD load at addr 6 (misaligned);
  - WORD load at addr 96 with MEM_BYTES=100 is legal;
  - WORD load at addr 98, and at 0xFFFFFFFC, are errors;
  - store with mode 100;
  - mode 111.
- Back-to-back: req_valid held high with two BYTE loads -> second accepted exactly 3 cycles after the first. req_valid toggled during ACCESS -> no effect.
- Assert rst asynchronously in the 2nd ACCESS cycle of a WORD store -> mem_wr_en drops immediately; no rsp_valid; req_ready=1 after release; only address 4 was written.
